// File: rtl/ann_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ann_layer_engine
//  Purpose  : Time-multiplexed single-MAC engine for a fully connected
//             network. It runs NUM_LAYERS layers, each with its own node count.
//             Activations ping-pong between two buffers. Weights arrive as a
//             stalled req/valid stream. The last layer is reduced by an argmax
//             scan.
//  Ports    : clk, n_rst (sync, active-low)
//             start_i, layer_nodes_i          - begin inference / per-layer sizes
//             img_valid_i, img_data_i, img_ready_o         - image word stream
//             coef_req_o, coef_layer_o, coef_node_o,
//             coef_valid_i, coef_data_i                    - weight stream
//             busy_o, result_valid_o, result_class_o,
//             result_value_o, cfg_err_o                    - status / result
//  Revision : 1.0  initial release
// ============================================================================
module ann_layer_engine #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int IN_SIZE    = 64,
  parameter int MAX_NODES  = 16,
  parameter int NUM_LAYERS = 3
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start_i,
  input  logic [NUM_LAYERS*8-1:0]  layer_nodes_i,
  input  logic                     img_valid_i,
  input  logic signed [DATA_W-1:0] img_data_i,
  output logic                     img_ready_o,
  output logic                     coef_req_o,
  output logic [7:0]               coef_layer_o,
  output logic [7:0]               coef_node_o,
  input  logic                     coef_valid_i,
  input  logic signed [DATA_W-1:0] coef_data_i,
  output logic                     busy_o,
  output logic                     result_valid_o,
  output logic [7:0]               result_class_o,
  output logic signed [DATA_W-1:0] result_value_o,
  output logic                     cfg_err_o
);

  localparam int ACC_W = 2*DATA_W + 8;
  localparam int AW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int LAST  = NUM_LAYERS - 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IMG, S_MAC, S_WRITE, S_SWAP, S_ARGMAX, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 nodes_q [NUM_LAYERS];
  logic [7:0]                 nodes_d [NUM_LAYERS];
  logic [LW-1:0]              layer_q, layer_d;
  logic [AW-1:0]              node_q, node_d;
  logic [AW-1:0]              in_idx_q, in_idx_d;
  logic [AW-1:0]              scan_q, scan_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       src_sel_q, src_sel_d;   // 0: src=A dst=B, 1: src=B dst=A
  logic signed [DATA_W-1:0]   best_val_q, best_val_d;
  logic [AW-1:0]              best_idx_q, best_idx_d;
  logic [7:0]                 res_class_q, res_class_d;
  logic signed [DATA_W-1:0]   res_value_q, res_value_d;
  logic                       cfg_err_q, cfg_err_d;

  logic signed [DATA_W-1:0]   buf_a_q [IN_SIZE];
  logic signed [DATA_W-1:0]   buf_b_q [IN_SIZE];

  logic                       cfg_bad;
  logic                       clr_all, clr_new_dst, img_we, dst_we;
  logic [7:0]                 n_in;
  logic                       in_last, node_last, scan_last, take;
  logic signed [DATA_W-1:0]   src_word, dst_word;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [DATA_W-1:0]   sat_y, y;

  always_comb begin
    cfg_bad = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (layer_nodes_i[8*k +: 8] == 8'd0 || layer_nodes_i[8*k +: 8] > 8'(MAX_NODES)) begin
        cfg_bad = 1'b1;
      end
    end
  end

  assign n_in      = (layer_q == '0) ? 8'(IN_SIZE) : nodes_q[layer_q - LW'(1)];
  assign in_last   = (32'(in_idx_q) == 32'(n_in) - 32'd1);
  assign node_last = (32'(node_q) == 32'(nodes_q[layer_q]) - 32'd1);
  assign scan_last = (32'(scan_q) == 32'(nodes_q[LAST]) - 32'd1);

  assign src_word  = src_sel_q ? buf_b_q[in_idx_q] : buf_a_q[in_idx_q];
  assign dst_word  = src_sel_q ? buf_a_q[scan_q]   : buf_b_q[scan_q];
  assign prod      = src_word * coef_data_i;

  // Fixed-point rescale, saturate, then ReLU on hidden layers only.
  assign shifted = acc_q >>> FRAC_W;
  always_comb begin
    if (shifted > SAT_MAX) begin
      sat_y = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_y = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_y = shifted[DATA_W-1:0];
    end
  end
  assign y = (layer_q != LW'(LAST) && sat_y[DATA_W-1]) ? '0 : sat_y;

  // Argmax: first entry always taken, later ones only if strictly greater,
  // so ties keep the lowest index.
  assign take = (scan_q == '0) || (dst_word > best_val_q);

  always_comb begin
    state_d     = state_q;
    nodes_d     = nodes_q;
    layer_d     = layer_q;
    node_d      = node_q;
    in_idx_d    = in_idx_q;
    scan_d      = scan_q;
    acc_d       = acc_q;
    src_sel_d   = src_sel_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    res_class_d = res_class_q;
    res_value_d = res_value_q;
    cfg_err_d   = 1'b0;
    clr_all     = 1'b0;
    clr_new_dst = 1'b0;
    img_we      = 1'b0;
    dst_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          for (int k = 0; k < NUM_LAYERS; k++) nodes_d[k] = layer_nodes_i[8*k +: 8];
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            clr_all   = 1'b1;
            in_idx_d  = '0;
            src_sel_d = 1'b0;
            state_d   = S_LOAD_IMG;
          end
        end
      end
      S_LOAD_IMG: begin
        if (img_valid_i) begin
          img_we = 1'b1;
          if (in_idx_q == AW'(IN_SIZE-1)) begin
            in_idx_d = '0;
            layer_d  = '0;
            node_d   = '0;
            acc_d    = '0;
            state_d  = S_MAC;
          end else begin
            in_idx_d = in_idx_q + AW'(1);
          end
        end
      end
      S_MAC: begin
        if (coef_valid_i) begin
          acc_d = acc_q + {{8{prod[2*DATA_W-1]}}, prod};
          if (in_last) state_d = S_WRITE;
          else         in_idx_d = in_idx_q + AW'(1);
        end
      end
      S_WRITE: begin
        dst_we   = 1'b1;
        acc_d    = '0;
        in_idx_d = '0;
        if (!node_last) begin
          node_d  = node_q + AW'(1);
          state_d = S_MAC;
        end else if (layer_q != LW'(LAST)) begin
          state_d = S_SWAP;
        end else begin
          scan_d  = '0;
          state_d = S_ARGMAX;
        end
      end
      S_SWAP: begin
        src_sel_d   = ~src_sel_q;
        clr_new_dst = 1'b1;
        layer_d     = layer_q + LW'(1);
        node_d      = '0;
        state_d     = S_MAC;
      end
      S_ARGMAX: begin
        if (take) begin
          best_val_d = dst_word;
          best_idx_d = scan_q;
        end
        if (scan_last) begin
          res_class_d = take ? 8'(scan_q) : 8'(best_idx_q);
          res_value_d = take ? dst_word : best_val_q;
          state_d     = S_DONE;
        end else begin
          scan_d = scan_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      nodes_q     <= '{default: '0};
      layer_q     <= '0;
      node_q      <= '0;
      in_idx_q    <= '0;
      scan_q      <= '0;
      acc_q       <= '0;
      src_sel_q   <= 1'b0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      res_class_q <= '0;
      res_value_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nodes_q     <= nodes_d;
      layer_q     <= layer_d;
      node_q      <= node_d;
      in_idx_q    <= in_idx_d;
      scan_q      <= scan_d;
      acc_q       <= acc_d;
      src_sel_q   <= src_sel_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      res_class_q <= res_class_d;
      res_value_q <= res_value_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Activation buffers carry no reset; they are cleared on every accepted start.
  // On SWAP the old source becomes the new destination and is zeroed.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      for (int i = 0; i < IN_SIZE; i++) begin
        buf_a_q[i] <= '0;
        buf_b_q[i] <= '0;
      end
    end else if (img_we) begin
      buf_a_q[in_idx_q] <= img_data_i;
    end else if (dst_we) begin
      if (src_sel_q) buf_a_q[node_q] <= y;
      else           buf_b_q[node_q] <= y;
    end else if (clr_new_dst) begin
      for (int i = 0; i < IN_SIZE; i++) begin
        if (src_sel_q) buf_b_q[i] <= '0;
        else           buf_a_q[i] <= '0;
      end
    end
  end

  assign img_ready_o    = (state_q == S_LOAD_IMG);
  assign coef_req_o     = (state_q == S_MAC);
  assign coef_layer_o   = 8'(layer_q);
  assign coef_node_o    = 8'(node_q);
  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = (state_q == S_DONE);
  assign result_class_o = res_class_q;
  assign result_value_o = res_value_q;
  assign cfg_err_o      = cfg_err_q;

endmodule
`default_nettype wire

// File: doc/ann_layer_engine.md
# ann_layer_engine

Parametrised successor to the fixed three-layer ANN datapath: a single time-multiplexed MAC engine runs a fully connected network with a configurable number of layers and a per-layer node count. Activations ping-pong between two on-chip buffers. Weights arrive as a stalled stream under a request/valid handshake. The final layer is reduced to a class index by an argmax scan. It sits between the image/weight loader and the seven-segment decoder, and reports `result_class` plus a one-cycle `result_valid`.

## Interface
- `DATA_W`, 16: signed fixed-point word width for activations and weights.
- `FRAC_W`, 8: fractional bits (1.0 = 0x0100).
- `IN_SIZE`, 64: image words; sets activation buffer depth.
- `MAX_NODES`, 16: largest legal node count for any layer.
- `NUM_LAYERS`, 3: number of layers processed per inference.

- `clk`  in  1  clock.
- `n_rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin inference; honoured only in IDLE.
- `layer_nodes`  in  NUM_LAYERS×8  node count per layer; sampled when `start` is accepted.
- `img_valid`  in  1  image word present.
- `img_data`  in  DATA_W  image word, index 0 first.
- `img_ready`  out  1  high in LOAD_IMG.
- `coef_req`  out  1  weights wanted for (`coef_layer`, `coef_node`).
- `coef_layer`  out  8  layer index of the requested weight row.
- `coef_node`  out  8  node index of the requested weight row.
- `coef_valid`  in  1  weight word present.
- `coef_data`  in  DATA_W  weight for the current input index.
- `busy`  out  1  high in every state except IDLE.
- `result_valid`  out  1  one-cycle pulse when the class is ready.
- `result_class`  out  8  argmax node index of the last layer.
- `result_value`  out  DATA_W  winning activation.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected for an illegal config.

## Operation
- States: IDLE → LOAD_IMG → MAC → WRITE → (MAC | SWAP | ARGMAX) → DONE → IDLE. SWAP returns to MAC.
- IDLE, `start`=1:
  - Latch `layer_nodes`.
  - If any entry is 0 or >MAX_NODES: pulse `cfg_err`, stay in IDLE.
  - Otherwise clear both buffers and enter LOAD_IMG.
- LOAD_IMG:
  - Each cycle with `img_valid`, write `img_data` to buffer A[idx] and increment idx.
  - After word IN_SIZE-1, go to MAC with layer=0, node=0.
- Input count per layer: layer 0 uses IN_SIZE; layer k uses `layer_nodes[k-1]`.
- MAC:
  - `coef_req`=1.
  - Each cycle with `coef_valid`: acc += src[in_idx] × `coef_data`, then in_idx++.
  - Accumulator is signed, 2·DATA_W+8 bits, and never overflows.
  - After the last input is accepted, go to WRITE. `coef_req` drops in the same cycle.
- WRITE:
  - y = acc >>> FRAC_W (arithmetic), saturated to the signed DATA_W range.
  - ReLU (negative → 0) on every layer except the last.
  - dst[node] = y. Clear acc and in_idx.
  - If node < `layer_nodes[layer]`-1: node++, go to MAC.
  - Else, if not the last layer: go to SWAP.
  - Else: go to ARGMAX.
- SWAP:
  - Exchange src and dst.
  - Zero the new dst so stale entries from a wider earlier layer read as 0.
  - layer++, node=0, go to MAC.
- ARGMAX:
  - Scan the last-layer entries one per cycle and keep the strictly greater value.
  - Ties resolve to the lowest index.
  - Go to DONE after the final entry.
- DONE: assert `result_valid` for one cycle with `result_class` and `result_value`, then go to IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset (`n_rst`=0 at a `clk` edge), from any state including mid-inference:
  - State returns to IDLE.
  - `img_ready`, `coef_req`, `busy`, `result_valid` and `cfg_err` all go to 0.
  - `result_class` and `result_value` go to 0.
  - Counters and acc are cleared.
  - Buffer contents are don't-care; they are cleared on the next accepted start.
- `start` accepted at edge t: `busy`=1 and `img_ready`=1 from t+1.
- Image load takes IN_SIZE cycles with no stalls. `img_ready` drops the cycle after the last word is accepted.
- `coef_layer` and `coef_node` are stable while `coef_req`=1. A `coef_valid` cycle with `coef_req`=0 is ignored.
- No-stall latency:
  - Per node: N_in + 1 cycles.
  - Per layer boundary: +1 cycle.
  - Argmax: + `layer_nodes[last]` cycles.
  - DONE: +1 cycle.
- `result_class` and `result_value` hold until the next DONE or reset.
- `cfg_err` is a pulse one cycle after `start`. `busy` stays 0 in that case.

## Test plan
- Identity routing:
  - Config: IN_SIZE=64, layers {16,8,10}, FRAC_W=8.
  - Image: word 5 = 0x0300, all others 0.
  - Weights: each node row is 0x0100 at one chosen index, 0 elsewhere, routed so only last-layer node 7 sees input 5.
  - Required: `result_class`=7, `result_value`=0x0300, `result_valid` high for exactly 1 cycle.
- ReLU and saturation:
  - A hidden node whose sum is -0x0200 must write 0.
  - A last-layer sum of 0x7F00 × 0x0400 must saturate to 0x7FFF.
  - The last layer must keep negative values: all last-layer outputs -0x0100 → `result_value`=0xFF00, class 0.
- Tie and stall:
  - Last-layer nodes 2 and 6 both 0x0200 → class 2.
  - Toggle `coef_valid` randomly at 50%; the result must match the no-stall run.
  - `coef_layer` and `coef_node` must not change while `coef_req` is high.
- Illegal configuration:
  - `layer_nodes` = {16,0,10} → `cfg_err` pulses once, `busy` stays 0, no `img_ready`.
  - `layer_nodes` = {17,8,10} → same response.
- Reset mid-MAC:
  - Drop `n_rst` during layer 1, node 3.
  - Next cycle: IDLE, all outputs 0.
  - A following full inference gives the correct class.
- Stale-buffer isolation:
  - Run layers {16,4,10}; layer 2 weights for inputs 4..15 are nonzero.
  - Result must equal the reference model that uses zeros for those inputs.
